// File: rtl/store_ctrl.sv
// store_ctrl: M-stage store issue controller for an SRAM-like data port.
// Formats SB/SH/SW stores into lane-replicated data plus byte strobes, then
// runs a single-outstanding request/response handshake while stalling the
// pipeline.
// Build option: define STORE_ADES_CHECK_EN to trap misaligned SH/SW as an
// address error instead of silently aligning them.

`ifndef EXE_SB_OP
`define EXE_SB_OP 8'b11101000
`endif
`ifndef EXE_SH_OP
`define EXE_SH_OP 8'b11101001
`endif
`ifndef EXE_SW_OP
`define EXE_SW_OP 8'b11101011
`endif

module store_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_validM,
  input  logic        flushM,
  input  logic [7:0]  alucontrolM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  output logic        adesM,
  output logic [31:0] badvaddrM,
  output logic        store_stall
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;

  logic            is_sb;
  logic            is_sh;
  logic            is_sw;
  logic            is_store;
  logic            misaligned;
  logic            accept;
  logic [1:0]      fmt_size;
  logic [AW-1:0]   fmt_addr;
  logic [DW-1:0]   fmt_wdata;
  logic [SW-1:0]   fmt_wstrb;

  // Store decode and payload formatting from the raw M-stage operands
  always_comb begin
    is_sb      = 1'b0;
    is_sh      = 1'b0;
    is_sw      = 1'b0;
    fmt_size   = 2'd0;
    fmt_addr   = aluoutM;
    fmt_wdata  = writedataM;
    fmt_wstrb  = 4'b0000;
    case (alucontrolM)
      `EXE_SB_OP: begin
        is_sb     = 1'b1;
        fmt_size  = 2'd0;
        fmt_addr  = aluoutM;
        fmt_wdata = {4{writedataM[7:0]}};
        fmt_wstrb = 4'b0001 << aluoutM[1:0];
      end
      `EXE_SH_OP: begin
        is_sh     = 1'b1;
        fmt_size  = 2'd1;
        fmt_addr  = {aluoutM[AW-1:1], 1'b0};
        fmt_wdata = {2{writedataM[15:0]}};
        fmt_wstrb = aluoutM[1] ? 4'b1100 : 4'b0011;
      end
      `EXE_SW_OP: begin
        is_sw     = 1'b1;
        fmt_size  = 2'd2;
        fmt_addr  = {aluoutM[AW-1:2], 2'b00};
        fmt_wdata = writedataM;
        fmt_wstrb = 4'b1111;
      end
      default: begin
        is_sb = 1'b0;
      end
    endcase
    is_store   = is_sb | is_sh | is_sw;
    misaligned = (is_sh & aluoutM[0]) | (is_sw & (aluoutM[1:0] != 2'b00));
  end

`ifdef STORE_ADES_CHECK_EN
  // Misaligned SH/SW raise an address error and are never issued
  always_comb begin
    adesM     = ~rst & (state == IDLE) & mem_validM & misaligned;
    badvaddrM = adesM ? aluoutM : 32'd0;
    accept    = ~rst & (state == IDLE) & mem_validM & ~flushM & is_store & ~misaligned;
  end
`else
  // Without the check, misaligned stores are issued with truncated addresses
  always_comb begin
    adesM     = 1'b0;
    badvaddrM = 32'd0;
    accept    = ~rst & (state == IDLE) & mem_validM & ~flushM & is_store;
  end
`endif

  // Pipeline hold: acceptance cycle, pending request, or waiting for write done
  always_comb begin
    store_stall = ~rst & (accept | (state == REQ) | ((state == RESP) & ~data_data_ok));
  end

  // Handshake FSM with registered request payload
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= 32'd0;
      data_wdata <= 32'd0;
      data_wstrb <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= REQ;
            data_req   <= 1'b1;
            data_wr    <= 1'b1;
            data_size  <= fmt_size;
            data_addr  <= fmt_addr;
            data_wdata <= fmt_wdata;
            data_wstrb <= fmt_wstrb;
          end
        end
        REQ: begin
          // An accepted request is committed even if a flush arrives with it
          if (data_addr_ok) begin
            data_req <= 1'b0;
            data_wr  <= 1'b0;
            state    <= data_data_ok ? IDLE : RESP;
          end else if (flushM) begin
            data_req <= 1'b0;
            data_wr  <= 1'b0;
            state    <= IDLE;
          end
        end
        RESP: begin
          if (data_data_ok) begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          data_req <= 1'b0;
          data_wr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/store_ctrl.md
STORE_CTRL -- requirements
Module: store_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 mem_validM  in  1  M-stage instruction valid, not being flushed this cycle.
REQ-004 flushM  in  1  exception/flush of M stage.
REQ-005 alucontrolM  in  8  op code; store ops are `EXE_SB_OP, `EXE_SH_OP and `EXE_SW_OP from defines.vh; other codes are non-stores.
REQ-006 aluoutM  in  32  effective byte address.
REQ-007 writedataM  in  32  rt value to store.
REQ-008 data_req / data_wr  out  1/1  SRAM-like request and write flag.
REQ-009 data_size  out  2  0=byte, 1=half, 2=word.
REQ-010 data_addr / data_wdata  out  32/32  request address and lane-replicated data.
REQ-011 data_wstrb  out  4  byte-lane enables.
REQ-012 data_addr_ok / data_data_ok  in  1/1  request accepted / write completed.
REQ-013 adesM  out  1  store address error; badvaddrM  out  32  faulting address.
REQ-014 store_stall  out  1  hold pipeline while a store is outstanding.

Function
REQ-015 Store accepted when state IDLE, mem_validM=1, flushM=0, op is a store and address is aligned.
REQ-016 Formatting: SB -> wdata {4{wd[7:0]}}, wstrb 4'b0001<<addr[1:0], size 0; SH -> wdata {2{wd[15:0]}}, wstrb 0011 (addr[1]=0) or 1100 (addr[1]=1), size 1; SW -> wdata wd, wstrb 1111, size 2.
REQ-017 On acceptance, addr/wdata/wstrb/size are registered; data_* outputs come only from these registers and stay stable until data_addr_ok.
REQ-018 FSM states IDLE, REQ, RESP; IDLE->REQ on acceptance; REQ->RESP on data_addr_ok; RESP->IDLE on data_data_ok.
REQ-019 REQ with data_addr_ok and data_data_ok in the same cycle -> IDLE directly.
REQ-020 data_req=1 and data_wr=1 only in REQ; at most one request outstanding.
REQ-021 Latency: acceptance cycle N, data_req first asserted cycle N+1.
REQ-022 store_stall = acceptance-cycle condition OR state REQ OR (state RESP AND NOT data_data_ok); stall deasserts in the data_data_ok cycle.
REQ-023 Inputs are ignored outside IDLE.
REQ-024 flushM=1 in REQ before data_addr_ok -> IDLE, no request issued; in the same cycle as data_addr_ok the request is committed and the FSM goes to RESP.
REQ-025 flushM in RESP is ignored; the write completes and stall holds until data_data_ok.
REQ-026 Non-store ops never assert data_req, adesM or store_stall.

Reset
REQ-027 rst=1 -> state IDLE, data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, data_wstrb=0, badvaddrM=0, store_stall=0, adesM=0.
REQ-028 Reset mid-transaction abandons it with no further request; any late data_ok is ignored in IDLE.

Configuration
REQ-029 Macro STORE_ADES_CHECK_EN.
REQ-030 Defined: mem_validM with SH and addr[0]=1, or SW and addr[1:0]!=0, asserts adesM combinationally and sets badvaddrM=aluoutM; the store is not accepted and there is no stall.
REQ-031 Not defined: adesM=0 and badvaddrM=0; misaligned SH uses addr[1] lanes and SW uses wstrb 1111; data_addr low bits are forced to 0 for SH (bit 0) and SW (bits 1:0).

Verification
REQ-032 SB addr 0x1003, wd 0x000000A5, addr_ok next cycle, data_ok 2 cycles later -> wdata 0xA5A5A5A5, wstrb 1000, size 0; stall for 4 cycles, then IDLE.
REQ-033 SH addr 0x2002, wd 0x1234BEEF, addr_ok and data_ok same cycle -> wdata 0xBEEFBEEF, wstrb 1100; REQ->IDLE directly.
REQ-034 SW addr 0x3001, STORE_ADES_CHECK_EN defined -> adesM=1, badvaddrM=0x3001, no data_req, stall=0; macro undefined -> data_addr 0x3000, wstrb 1111.
REQ-035 SW in REQ with addr_ok held 0 for 3 cycles, flushM=1 in cycle 2 -> IDLE, data_req never sampled accepted.
REQ-036 rst asserted in RESP -> all outputs 0 next cycle; data_data_ok arriving afterwards -> no state change.
